// File: rtl/mem_responder_if.sv
// Core-to-memory request/response bundle for mem_responder.
// mem_err exists only when MEM_RESP_BUSERR_EN is defined.
interface mem_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] d_addr;
  logic [31:0] dout;
  logic [31:0] din;
  logic        mem_ack;
  logic        mem_busy;
`ifdef MEM_RESP_BUSERR_EN
  logic        mem_err;

  modport master (
    output mem_req, mem_we, d_addr, dout,
    input  din, mem_ack, mem_busy, mem_err
  );

  modport slave (
    input  mem_req, mem_we, d_addr, dout,
    output din, mem_ack, mem_busy, mem_err
  );
`else
  modport master (
    output mem_req, mem_we, d_addr, dout,
    input  din, mem_ack, mem_busy
  );

  modport slave (
    input  mem_req, mem_we, d_addr, dout,
    output din, mem_ack, mem_busy
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// Word-organised data-memory responder with programmable wait states.
// Optional MEM_RESP_BUSERR_EN flags out-of-range addresses instead of aliasing them.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [31:0]   r_din;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_addr_err;

`ifdef MEM_RESP_BUSERR_EN
  assign w_addr_err = ({1'b0, bus.d_addr} >= (33'(DEPTH_WORDS) * 33'd4));
`else
  // Byte offset and upper bits are dropped, so addresses alias modulo the array size.
  logic w_unused;
  assign w_unused   = ^{bus.d_addr[1:0], bus.d_addr[31:AW+2]};
  assign w_addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_din   <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.mem_req) begin
            r_idx   <= bus.d_addr[AW+1:2];
            r_we    <= bus.mem_we;
            r_wdata <= bus.dout;
            r_err   <= w_addr_err;
            if (WAIT_STATES == 0) begin
              r_state <= S_ACCESS;
            end else begin
              r_cnt   <= 4'(WAIT_STATES - 1);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            r_din <= r_err ? '0 : r_mem[r_idx];
          end
          r_state <= S_ACK;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset during ACCESS must drop the write, so the array port is gated by rst too.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_ACCESS) && r_we && !r_err) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.din      = r_din;
  assign bus.mem_ack  = (r_state == S_ACK);
  assign bus.mem_busy = (r_state != S_IDLE);
`ifdef MEM_RESP_BUSERR_EN
  assign bus.mem_err  = (r_state == S_ACK) && r_err;
`endif

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's data-memory request interface.
- Accepts a request (mem_req, mem_we, d_addr, dout) from the core datapath and performs a full 32-bit word read or write on an internal word-organised RAM.
- Returns read data on din and acknowledges with a one-cycle mem_ack after a configurable number of wait states.
- The core does its own byte/halfword merge on din/dout, including read-modify-write; this block only moves aligned words.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; must be a power of two, minimum 4.
- WAIT_STATES, 1: extra cycles inserted between acceptance and array access; legal range 0..15.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- mem_req  input  1  core requests a memory transaction; sampled only in IDLE.
- mem_we  input  1  1 = write, 0 = read; latched with mem_req.
- d_addr  input  32  byte address from the core; bits [1:0] are ignored.
- dout  input  32  write data from the core (already byte-merged); latched with mem_req.
- din  output  32  registered read data to the core, big-endian word (byte 0 is in [31:24]).
- mem_ack  output  1  one-cycle pulse marking completion of the accepted transaction.
- mem_busy  output  1  high whenever the FSM is not in IDLE.
- mem_err  output  1  bus-error flag; present only with MEM_RESP_BUSERR_EN (see below).

Behaviour:
- Clocking and reset: single clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, din=0, mem_ack=0, mem_busy=0, mem_err=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, ACK.
- IDLE:
  - If mem_req=1, latch word index = d_addr[2+log2(DEPTH_WORDS)-1:2], mem_we and dout.
  - Go to WAIT with wait counter = WAIT_STATES-1, or go directly to ACCESS if WAIT_STATES=0.
  - Otherwise stay in IDLE.
- WAIT: decrement the counter; when it is 0, go to ACCESS.
- ACCESS:
  - Write: RAM[index] <= latched data; din is unchanged.
  - Read: din <= RAM[index].
  - Go to ACK.
- ACK: mem_ack=1 for exactly this cycle; next state is IDLE.
- Latency: request sampled in cycle N, mem_ack high in cycle N+WAIT_STATES+2. Read data is valid on din in the ACK cycle and holds until the next read's ACCESS.
- Back-to-back requests: if mem_req is still high in the IDLE cycle after ACK, it is accepted as a new request. The minimum spacing between accepts is WAIT_STATES+3 cycles.
- Input changes: while mem_busy=1, changes on mem_req, mem_we, d_addr and dout are ignored; only the latched values are used.
- Address wrap without the optional feature: upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4. Vector addresses 0 and 4 map to words 0 and 1.
- Reset mid-operation: rst has priority in every state. An aborted transaction is dropped with no RAM write (including rst asserted during ACCESS) and no mem_ack.
- Simultaneous mem_req and rst: reset wins and the request is not accepted.

Optional Feature:
- Macro: MEM_RESP_BUSERR_EN.
- When defined:
  - At acceptance, if d_addr >= DEPTH_WORDS*4, set an error flag.
  - In ACCESS, suppress the write, or load din=0 for a read.
  - mem_err=1 together with mem_ack in the ACK cycle, 0 at all other times.
  - Timing is identical to the non-error case.
- When undefined: the mem_err port is absent and out-of-range addresses alias as described above.

Test Plan:
- WAIT_STATES=1, write 0xDEADBEEF to 0x10, then read 0x10: mem_ack in cycle N+3 for each; read returns din=0xDEADBEEF.
- Read byte address 0x13 after the write above: din=0xDEADBEEF (low bits ignored); the core-visible byte at offset 3 is 0xEF.
- DEPTH_WORDS=1024, write 0x12345678 to 0x1000, then read 0x0: din=0x12345678 (alias). With MEM_RESP_BUSERR_EN: mem_err=1 with mem_ack, din=0, word 0 unchanged.
- WAIT_STATES=0, mem_req held high with 4 alternating reads and writes: mem_ack every 3 cycles; mem_busy=0 only in the accept cycles; data correct.
- Accept a write of 0xCAFEF00D to 0x20, change d_addr and dout while busy: 0x20 receives 0xCAFEF00D and the changed address is untouched.
- WAIT_STATES=3, write 0x55AA55AA to 0x8, assert rst for 1 cycle in WAIT: no mem_ack; all outputs 0; reading 0x8 returns its prior value.
